srt4_div_ctrl: RTL and testbench

SRT4_DIV_CTRL -- requirements
Module: srt4_div_ctrl

---
 rtl/srt4_div_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_srt4_div_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/srt4_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : srt4_div_ctrl
// Brief    : Control FSM for a radix-4 SRT single-precision divider.
// Revision : 1.0  initial release
// ============================================================================
module srt4_div_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        ready,
  output logic        dp_load,
  output logic        dp_step,
  output logic [23:0] dp_man_a,
  output logic [23:0] dp_man_b,
  input  logic [25:0] dp_quot,
  output logic        res_sign,
  output logic [7:0]  res_exp,
  output logic [22:0] res_mant,
  output logic        res_valid,
  output logic        invalid,
  output logic        div_by_zero
);

  localparam logic [2:0] C_IDLE  = 3'd0;
  localparam logic [2:0] C_CHECK = 3'd1;
  localparam logic [2:0] C_LOAD  = 3'd2;
  localparam logic [2:0] C_ITER  = 3'd3;
  localparam logic [2:0] C_NORM  = 3'd4;
  localparam logic [2:0] C_DONE  = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, b_q;
  logic        sign_q;
  logic [9:0]  exp_q;
  logic [23:0] man_a_q, man_b_q;
  logic        res_sign_q, inv_q, dbz_q;
  logic [7:0]  res_exp_q;
  logic [22:0] res_mant_q;

  logic [7:0] w_ea, w_eb;
  logic       w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic       w_sp_nan, w_sp_dbz, w_sp_inf, w_sp_zero, w_special;
  logic [9:0] w_e, w_norm_exp;
  logic       w_ovf, w_unf;
  logic       w_unused;

  assign w_ea     = a_q[30:23];
  assign w_eb     = b_q[30:23];
  assign w_a_zero = (w_ea == 8'd0);
  assign w_b_zero = (w_eb == 8'd0);
  assign w_a_inf  = (w_ea == 8'hFF) && (a_q[22:0] == 23'd0);
  assign w_b_inf  = (w_eb == 8'hFF) && (b_q[22:0] == 23'd0);
  assign w_a_nan  = (w_ea == 8'hFF) && (a_q[22:0] != 23'd0);
  assign w_b_nan  = (w_eb == 8'hFF) && (b_q[22:0] != 23'd0);

  // Special cases in priority order; each later term assumes the earlier ones are false.
  assign w_sp_nan  = w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf);
  assign w_sp_dbz  = !w_sp_nan & w_b_zero & !w_a_inf;
  assign w_sp_inf  = !w_sp_nan & w_a_inf;
  assign w_sp_zero = !w_sp_nan & !w_sp_dbz & !w_sp_inf & (w_a_zero | w_b_inf);
  assign w_special = w_sp_nan | w_sp_dbz | w_sp_inf | w_sp_zero;

  assign w_e        = {2'b00, w_ea} - {2'b00, w_eb} + 10'd127;
  assign w_norm_exp = dp_quot[25] ? exp_q : (exp_q - 10'd1);
  assign w_ovf      = ($signed(w_norm_exp) >= $signed(10'sd255));
  assign w_unf      = ($signed(w_norm_exp) <= $signed(10'sd0));
  assign w_unused   = dp_quot[0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= C_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      C_IDLE:  if (start) state_d = C_CHECK;
      C_CHECK: state_d = w_special ? C_DONE : C_LOAD;
      C_LOAD: begin
        state_d = C_ITER;
        cnt_d   = 4'd12;
      end
      C_ITER: begin
        if (cnt_q == 4'd0) state_d = C_NORM;
        else               cnt_d   = cnt_q - 4'd1;
      end
      C_NORM:  state_d = C_DONE;
      C_DONE:  state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  always_comb begin
    ready     = (state_q == C_IDLE);
    dp_load   = (state_q == C_LOAD);
    dp_step   = (state_q == C_ITER);
    res_valid = (state_q == C_DONE);
  end

  // Operand capture, mantissa hand-off and result registers; results change only on entry to DONE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      sign_q     <= 1'b0;
      exp_q      <= 10'd0;
      man_a_q    <= 24'd0;
      man_b_q    <= 24'd0;
      res_sign_q <= 1'b0;
      res_exp_q  <= 8'd0;
      res_mant_q <= 23'd0;
      inv_q      <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      case (state_q)
        C_IDLE: begin
          if (start) begin
            a_q <= op_a;
            b_q <= op_b;
          end
        end
        C_CHECK: begin
          sign_q <= a_q[31] ^ b_q[31];
          exp_q  <= w_e;
          if (w_special) begin
            inv_q <= w_sp_nan;
            dbz_q <= w_sp_dbz;
            if (w_sp_nan) begin
              res_sign_q <= 1'b0;
              res_exp_q  <= 8'hFF;
              res_mant_q <= 23'h400000;
            end else begin
              res_sign_q <= a_q[31] ^ b_q[31];
              res_exp_q  <= w_sp_zero ? 8'h00 : 8'hFF;
              res_mant_q <= 23'd0;
            end
          end else begin
            man_a_q <= {1'b1, a_q[22:0]};
            man_b_q <= {1'b1, b_q[22:0]};
          end
        end
        C_NORM: begin
          res_sign_q <= sign_q;
          inv_q      <= 1'b0;
          dbz_q      <= 1'b0;
          if (w_ovf) begin
            res_exp_q  <= 8'hFF;
            res_mant_q <= 23'd0;
          end else if (w_unf) begin
            res_exp_q  <= 8'h00;
            res_mant_q <= 23'd0;
          end else begin
            res_exp_q  <= w_norm_exp[7:0];
            res_mant_q <= dp_quot[25] ? dp_quot[24:2] : dp_quot[23:1];
          end
        end
        default: ;
      endcase
    end
  end

  assign dp_man_a    = man_a_q;
  assign dp_man_b    = man_b_q;
  assign res_sign    = res_sign_q;
  assign res_exp     = res_exp_q;
  assign res_mant    = res_mant_q;
  assign invalid     = inv_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_srt4_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_srt4_div_ctrl
// Brief    : Self-checking bench for srt4_div_ctrl with a result scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_srt4_div_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        ready, dp_load, dp_step, res_valid, invalid, div_by_zero, res_sign;
  logic [23:0] dp_man_a, dp_man_b;
  logic [25:0] dp_quot = 26'd0;
  logic [7:0]  res_exp;
  logic [22:0] res_mant;

  typedef struct {
    logic [31:0] res;
    logic        inv;
    logic        dbz;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          steps = 0;
  int          loads = 0;
  int          man_bad = 0;
  logic [23:0] exp_man_a = 24'd0;
  logic [23:0] exp_man_b = 24'd0;

  srt4_div_ctrl dut (
    .clk(clk), .resetn(resetn), .start(start), .op_a(op_a), .op_b(op_b),
    .ready(ready), .dp_load(dp_load), .dp_step(dp_step),
    .dp_man_a(dp_man_a), .dp_man_b(dp_man_b), .dp_quot(dp_quot),
    .res_sign(res_sign), .res_exp(res_exp), .res_mant(res_mant),
    .res_valid(res_valid), .invalid(invalid), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Scoreboard side: every result strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (dp_step === 1'b1) steps++;
    if (dp_load === 1'b1) loads++;
    if ((dp_load === 1'b1 || dp_step === 1'b1) &&
        (dp_man_a !== exp_man_a || dp_man_b !== exp_man_b)) man_bad++;
    if (res_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_res_valid got=%h exp=none", {res_sign, res_exp, res_mant});
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({res_sign, res_exp, res_mant} !== e.res || invalid !== e.inv || div_by_zero !== e.dbz) begin
          bad++;
          $display("FAIL result got=%h inv=%b dbz=%b exp=%h inv=%b dbz=%b",
                   {res_sign, res_exp, res_mant}, invalid, div_by_zero, e.res, e.inv, e.dbz);
        end
      end
    end
  end

  // glitch_at > 0 pulses start with a different operand pair in that cycle.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [25:0] q,
                         input logic [31:0] er, input logic ei, input logic ed,
                         input int lat, input int glitch_at, input string name);
    int   n;
    exp_t e;
    @(negedge clk);
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready got=%b exp=1", name, ready);
    end
    op_a = a; op_b = b; dp_quot = q; start = 1'b1;
    exp_man_a = {1'b1, a[22:0]};
    exp_man_b = {1'b1, b[22:0]};
    steps = 0; loads = 0; man_bad = 0;
    e.res = er; e.inv = ei; e.dbz = ed;
    sb.push_back(e);
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == glitch_at) begin
        start = 1'b1; op_a = 32'h3F800000; op_b = 32'h7F800000;
      end else begin
        start = 1'b0; op_a = a; op_b = b;
      end
    end while (res_valid !== 1'b1 && n < 40);
    start = 1'b0;
    total++;
    if (res_valid !== 1'b1 || n != lat) begin
      bad++;
      $display("FAIL %s_latency got=%0d exp=%0d", name, n, lat);
    end
    total++;
    if (steps != ((lat == 17) ? 13 : 0) || loads != ((lat == 17) ? 1 : 0)) begin
      bad++;
      $display("FAIL %s_strobes got steps=%0d loads=%0d exp steps=%0d loads=%0d",
               name, steps, loads, (lat == 17) ? 13 : 0, (lat == 17) ? 1 : 0);
    end
    if (lat == 17) begin
      total++;
      if (man_bad != 0) begin
        bad++;
        $display("FAIL %s_mantissa got bad_cycles=%0d exp=0", name, man_bad);
      end
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (ready !== 1'b1 || dp_load !== 1'b0 || dp_step !== 1'b0 || res_valid !== 1'b0 ||
        dp_man_a !== 24'd0 || dp_man_b !== 24'd0 || {res_sign, res_exp, res_mant} !== 32'd0 ||
        invalid !== 1'b0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got ready=%b load=%b step=%b rv=%b res=%h exp ready=1 rest=0",
               ready, dp_load, dp_step, res_valid, {res_sign, res_exp, res_mant});
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_ordinary();
    run_div(32'h40C00000, 32'h40000000, 26'h3000000, 32'h40400000, 1'b0, 1'b0, 17, 0, "div_6_2");
    run_div(32'h3F800000, 32'h3FC00000, 26'h1555555, 32'h3F2AAAAA, 1'b0, 1'b0, 17, 0, "div_1_1p5");
    run_div(32'hC0C00000, 32'h40000000, 26'h3000000, 32'hC0400000, 1'b0, 1'b0, 17, 0, "div_m6_2");
  endtask

  task automatic test_special();
    run_div(32'h40A00000, 32'h00000000, 26'h0, 32'h7F800000, 1'b0, 1'b1, 2, 0, "div_5_0");
    run_div(32'h00000000, 32'h00000000, 26'h0, 32'h7FC00000, 1'b1, 1'b0, 2, 0, "div_0_0");
    run_div(32'hFF800000, 32'h40000000, 26'h0, 32'hFF800000, 1'b0, 1'b0, 2, 0, "div_minf_2");
    run_div(32'h7FC00001, 32'h3F800000, 26'h0, 32'h7FC00000, 1'b1, 1'b0, 2, 0, "div_nan_1");
    run_div(32'h7F800000, 32'hFF800000, 26'h0, 32'h7FC00000, 1'b1, 1'b0, 2, 0, "div_inf_inf");
    run_div(32'h7F800000, 32'h00000000, 26'h0, 32'h7F800000, 1'b0, 1'b0, 2, 0, "div_inf_0");
    run_div(32'h40000000, 32'hFF800000, 26'h0, 32'h80000000, 1'b0, 1'b0, 2, 0, "div_2_minf");
    run_div(32'h00000000, 32'hC0000000, 26'h0, 32'h80000000, 1'b0, 1'b0, 2, 0, "div_0_m2");
    repeat (3) @(negedge clk);
    total++;
    if ({res_sign, res_exp, res_mant} !== 32'h80000000 || invalid !== 1'b0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL result_hold got=%h exp=80000000", {res_sign, res_exp, res_mant});
    end
  endtask

  task automatic test_ovf_unf();
    run_div(32'h7F000000, 32'h00800000, 26'h2000000, 32'h7F800000, 1'b0, 1'b0, 17, 0, "overflow");
    run_div(32'h00800000, 32'h7F000000, 26'h2000000, 32'h00000000, 1'b0, 1'b0, 17, 0, "underflow");
  endtask

  task automatic test_start_ignored();
    run_div(32'h40C00000, 32'h40000000, 26'h3000000, 32'h40400000, 1'b0, 1'b0, 17, 6, "start_in_iter");
    repeat (20) @(negedge clk);
    total++;
    if (ready !== 1'b1 || sb.size() != 0) begin
      bad++;
      $display("FAIL start_in_iter_idle got ready=%b pending=%0d exp ready=1 pending=0", ready, sb.size());
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    op_a = 32'h40C00000; op_b = 32'h40000000; dp_quot = 26'h3000000; start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    resetn = 1'b0;
    #1;
    total++;
    if (ready !== 1'b1 || dp_step !== 1'b0 || dp_load !== 1'b0 || res_valid !== 1'b0 ||
        dp_man_a !== 24'd0 || dp_man_b !== 24'd0 || {res_sign, res_exp, res_mant} !== 32'd0 ||
        invalid !== 1'b0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL midflight_reset got ready=%b step=%b man_a=%h res=%h exp ready=1 rest=0",
               ready, dp_step, dp_man_a, {res_sign, res_exp, res_mant});
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    run_div(32'h3F800000, 32'h3FC00000, 26'h1555555, 32'h3F2AAAAA, 1'b0, 1'b0, 17, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    run_div(32'h40C00000, 32'h40000000, 26'h3000000, 32'h40400000, 1'b0, 1'b0, 17, 0, "b2b_first");
    run_div(32'h3F800000, 32'h3FC00000, 26'h1555555, 32'h3F2AAAAA, 1'b0, 1'b0, 17, 0, "b2b_second");
    run_div(32'h40A00000, 32'h80000000, 26'h0, 32'hFF800000, 1'b0, 1'b1, 2, 0, "b2b_third");
  endtask

  initial begin
    test_reset();
    test_ordinary();
    test_special();
    test_ovf_unf();
    test_start_ignored();
    test_reset_midflight();
    test_back_to_back();
    repeat (5) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got pending=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
